// File: rtl/elevator_controller.sv
// elevator_controller: 3-floor car sequencer fed by synchronised hall calls and step ticks.
// Optional EMERGENCY_STOP_EN adds an estop input that freezes the FSM in place.
module elevator_controller #(
  parameter int TRAVEL_TICKS = 2,
  parameter int DOOR_TICKS   = 3,
  parameter int TICK_W       = 4
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       step,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
`ifdef EMERGENCY_STOP_EN
  input  logic       estop,
`endif
  output logic       moving,
  output logic [1:0] floor,
  output logic       dir_up,
  output logic       door_open,
  output logic [2:0] requests
);

  typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, DOOR = 2'd2} state_t;

  localparam logic [TICK_W-1:0] TRAVEL_LAST = TICK_W'(TRAVEL_TICKS - 1);
  localparam logic [TICK_W-1:0] DOOR_LAST   = TICK_W'(DOOR_TICKS - 1);

  state_t            state_reg, state_next;
  logic [1:0]        floor_reg, floor_next;
  logic              dir_up_reg, dir_up_next;
  logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
  logic [2:0]        requests_reg, requests_next;
  logic [2:0]        button_raw;
  logic [2:0]        press;
  logic [2:0]        step_sync_reg;
  logic              tick;
  logic              frozen;

  function automatic logic [2:0] floor_mask(input logic [1:0] f);
    case (f)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic calls_ahead(input logic [2:0] req, input logic [1:0] f,
                                       input logic up);
    logic [2:0] above;
    logic [2:0] below;
    case (f)
      2'd0:    begin above = 3'b110; below = 3'b000; end
      2'd1:    begin above = 3'b100; below = 3'b001; end
      2'd2:    begin above = 3'b000; below = 3'b011; end
      default: begin above = 3'b000; below = 3'b000; end
    endcase
    return |(req & (up ? above : below));
  endfunction

  // Saturating one-floor step in the current direction.
  function automatic logic [1:0] floor_step(input logic [1:0] f, input logic up);
    if (up) return (f == 2'd2) ? 2'd2 : f + 2'd1;
    else    return (f == 2'd0) ? 2'd0 : f - 2'd1;
  endfunction

  assign button_raw = {button3, button2, button1};

  // [0],[1] form the synchroniser; [2] holds the previous synchronised level for edge detect.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn_sync
      logic [2:0] sync_reg;
      always_ff @(posedge clk_50) begin
        if (reset) sync_reg <= 3'b111;
        else       sync_reg <= {sync_reg[1:0], button_raw[gi]};
      end
      assign press[gi] = sync_reg[2] & ~sync_reg[1];
    end
  endgenerate

  always_ff @(posedge clk_50) begin
    if (reset) step_sync_reg <= 3'b000;
    else       step_sync_reg <= {step_sync_reg[1:0], step};
  end
  assign tick = step_sync_reg[1] & ~step_sync_reg[2];

`ifdef EMERGENCY_STOP_EN
  logic [1:0] estop_sync_reg;
  always_ff @(posedge clk_50) begin
    if (reset) estop_sync_reg <= 2'b00;
    else       estop_sync_reg <= {estop_sync_reg[0], estop};
  end
  assign frozen = estop_sync_reg[1];
`else
  assign frozen = 1'b0;
`endif

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_reg    <= IDLE;
      floor_reg    <= 2'd0;
      dir_up_reg   <= 1'b0;
      tick_cnt_reg <= '0;
      requests_reg <= 3'b000;
    end else begin
      state_reg    <= state_next;
      floor_reg    <= floor_next;
      dir_up_reg   <= dir_up_next;
      tick_cnt_reg <= tick_cnt_next;
      requests_reg <= requests_next;
    end
  end

  always_comb begin
    logic [2:0] cur_mask;
    logic [2:0] adv_mask;
    logic [2:0] req_clear;
    logic [2:0] req_set;
    logic [1:0] floor_adv;
    logic       door_reload;

    state_next    = state_reg;
    floor_next    = floor_reg;
    dir_up_next   = dir_up_reg;
    tick_cnt_next = tick_cnt_reg;
    req_clear     = 3'b000;
    cur_mask      = floor_mask(floor_reg);
    floor_adv     = floor_step(floor_reg, dir_up_reg);
    adv_mask      = floor_mask(floor_adv);
    // A call for the floor whose doors are open restarts the door timer instead of latching.
    door_reload   = (state_reg == DOOR) && |(press & cur_mask);
    req_set       = press & ~((state_reg == DOOR) ? cur_mask : 3'b000);

    if (!frozen) begin
      unique case (state_reg)
        IDLE: begin
          if (|(requests_reg & cur_mask)) begin
            req_clear  = cur_mask;
            state_next = DOOR;
          end else if (calls_ahead(requests_reg, floor_reg, dir_up_reg)) begin
            state_next = MOVE;
          end else if (calls_ahead(requests_reg, floor_reg, ~dir_up_reg)) begin
            dir_up_next = ~dir_up_reg;
            state_next  = MOVE;
          end
        end
        MOVE: begin
          if (tick) begin
            if (tick_cnt_reg == TRAVEL_LAST) begin
              floor_next    = floor_adv;
              tick_cnt_next = '0;
              if (|(requests_reg & adv_mask)) begin
                req_clear  = adv_mask;
                state_next = DOOR;
              end else if (!calls_ahead(requests_reg, floor_adv, dir_up_reg)) begin
                state_next = IDLE;
              end
            end else begin
              tick_cnt_next = tick_cnt_reg + 1'b1;
            end
          end
        end
        DOOR: begin
          if (door_reload) begin
            tick_cnt_next = '0;
          end else if (tick) begin
            if (tick_cnt_reg == DOOR_LAST) state_next = IDLE;
            else                           tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
      if (state_next != state_reg) tick_cnt_next = '0;
    end

    requests_next = (requests_reg & ~req_clear) | req_set;
  end

  always_comb begin
    moving    = (state_reg == MOVE) && !frozen;
    door_open = (state_reg == DOOR);
  end

  assign floor    = floor_reg;
  assign dir_up   = dir_up_reg;
  assign requests = requests_reg;

endmodule

// File: tb/tb_elevator_controller.sv
// tb_elevator_controller: directed vector table plus randomized run against a reference model.
// Build with EMERGENCY_STOP_EN defined to also exercise the estop freeze.
module tb_elevator_controller;

  localparam int TRAVEL = 2;
  localparam int DOORT  = 3;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b1;
  logic       step = 1'b0;
  logic       button1 = 1'b1;
  logic       button2 = 1'b1;
  logic       button3 = 1'b1;
`ifdef EMERGENCY_STOP_EN
  logic       estop = 1'b0;
`endif
  logic       moving;
  logic [1:0] floor;
  logic       dir_up;
  logic       door_open;
  logic [2:0] requests;

  elevator_controller #(.TRAVEL_TICKS(TRAVEL), .DOOR_TICKS(DOORT), .TICK_W(4)) dut (
    .clk_50    (clk_50),
    .reset     (reset),
    .step      (step),
    .button1   (button1),
    .button2   (button2),
    .button3   (button3),
`ifdef EMERGENCY_STOP_EN
    .estop     (estop),
`endif
    .moving    (moving),
    .floor     (floor),
    .dir_up    (dir_up),
    .door_open (door_open),
    .requests  (requests)
  );

  always #5 clk_50 = ~clk_50;

  int n_vec = 0;
  int n_bad = 0;

  // Observation bundle {moving, door_open, floor, dir_up, requests}
  logic [7:0] dut_bits;
  assign dut_bits = {moving, door_open, floor, dir_up, requests};

  // ---------------- reference model ----------------
  typedef enum int {C_IDLE, C_MOVE, C_DOOR} car_t;
  car_t       m_state = C_IDLE;
  int         m_floor = 0;
  logic       m_up = 1'b0;
  int         m_seen = 0;          // ticks seen since entering the current state
  logic [2:0] m_req = 3'b000;
  logic [3:0] hist [0:2];          // sampled {step, button3, button2, button1}, [0] newest

  initial for (int k = 0; k < 3; k++) hist[k] = 4'b0111;

  function automatic logic pending_toward(input logic [2:0] r, input int f, input logic up);
    for (int k = 0; k < 3; k++)
      if (r[k] && ((up && k > f) || (!up && k < f))) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk_50) begin : ref_model
    logic [2:0] prs;
    logic       tck;
    logic [2:0] rq;
    logic [2:0] latch;
    car_t       st;
    int         fl;
    int         cnt;
    logic       up;
    if (reset) begin
      for (int k = 0; k < 3; k++) hist[k] <= 4'b0111;
      m_state <= C_IDLE; m_floor <= 0; m_up <= 1'b0; m_seen <= 0; m_req <= 3'b000;
    end else begin
      // An input edge takes effect three clock edges after it is first sampled.
      for (int k = 0; k < 3; k++) prs[k] = !hist[1][k] && hist[2][k];
      tck = hist[1][3] && !hist[2][3];
      hist[0] <= {step, button3, button2, button1};
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      st = m_state; fl = m_floor; up = m_up; cnt = m_seen; rq = m_req;
      latch = prs;
      if (m_state == C_DOOR) latch[m_floor] = 1'b0;
      case (m_state)
        C_IDLE: begin
          if (m_req[fl]) begin rq[fl] = 1'b0; st = C_DOOR; cnt = 0; end
          else if (pending_toward(m_req, fl, up)) begin st = C_MOVE; cnt = 0; end
          else if (pending_toward(m_req, fl, !up)) begin up = !up; st = C_MOVE; cnt = 0; end
        end
        C_MOVE: if (tck) begin
          cnt = cnt + 1;
          if (cnt == TRAVEL) begin
            fl = up ? fl + 1 : fl - 1;
            if (fl > 2) fl = 2;
            if (fl < 0) fl = 0;
            cnt = 0;
            if (m_req[fl]) begin rq[fl] = 1'b0; st = C_DOOR; end
            else if (!pending_toward(m_req, fl, up)) st = C_IDLE;
          end
        end
        C_DOOR: begin
          if (prs[fl]) cnt = 0;
          else if (tck) begin
            cnt = cnt + 1;
            if (cnt == DOORT) begin st = C_IDLE; cnt = 0; end
          end
        end
        default: st = C_IDLE;
      endcase
      m_state <= st; m_floor <= fl; m_up <= up; m_seen <= cnt; m_req <= rq | latch;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: {mv,door,floor,up,req} got %b_%b_%0d_%b_%b required %b_%b_%0d_%b_%b",
               name, got[7], got[6], got[5:4], got[3], got[2:0],
               exp[7], exp[6], exp[5:4], exp[3], exp[2:0]);
    end
  endtask

  // All drive tasks are entered and left at a falling edge.
  task automatic press_buttons(input logic [2:0] mask);
    button1 = ~mask[0]; button2 = ~mask[1]; button3 = ~mask[2];
    repeat (2) @(negedge clk_50);
    button1 = 1'b1; button2 = 1'b1; button3 = 1'b1;
    repeat (8) @(negedge clk_50);
  endtask

  task automatic give_tick();
    step = 1'b1;
    repeat (2) @(negedge clk_50);
    step = 1'b0;
    repeat (8) @(negedge clk_50);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk_50);
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic [2:0] press;   // bit i low on button(i+1)
    logic [3:0] ticks;
    logic [7:0] exp;     // {moving, door_open, floor, dir_up, requests}
  } vec_t;

  localparam int NVEC = 21;
  vec_t tbl [0:NVEC-1];

  initial begin
    // press  ticks   mv dr fl  up req
    tbl[0]  = {3'b000, 4'd0, 8'b0_0_00_0_000};
    tbl[1]  = {3'b010, 4'd0, 8'b1_0_00_1_010};
    tbl[2]  = {3'b000, 4'd1, 8'b1_0_00_1_010};
    tbl[3]  = {3'b000, 4'd1, 8'b0_1_01_1_000};
    tbl[4]  = {3'b000, 4'd2, 8'b0_1_01_1_000};
    tbl[5]  = {3'b000, 4'd1, 8'b0_0_01_1_000};
    tbl[6]  = {3'b010, 4'd0, 8'b0_1_01_1_000};
    tbl[7]  = {3'b000, 4'd2, 8'b0_1_01_1_000};
    tbl[8]  = {3'b010, 4'd0, 8'b0_1_01_1_000};
    tbl[9]  = {3'b000, 4'd2, 8'b0_1_01_1_000};
    tbl[10] = {3'b000, 4'd1, 8'b0_0_01_1_000};
    tbl[11] = {3'b111, 4'd0, 8'b0_1_01_1_101};
    tbl[12] = {3'b000, 4'd3, 8'b1_0_01_1_101};
    tbl[13] = {3'b000, 4'd2, 8'b0_1_10_1_001};
    tbl[14] = {3'b000, 4'd3, 8'b1_0_10_0_001};
    tbl[15] = {3'b000, 4'd2, 8'b1_0_01_0_001};
    tbl[16] = {3'b010, 4'd0, 8'b1_0_01_0_011};
    tbl[17] = {3'b000, 4'd2, 8'b0_1_00_0_010};
    tbl[18] = {3'b000, 4'd3, 8'b1_0_00_1_010};
    tbl[19] = {3'b000, 4'd2, 8'b0_1_01_1_000};
    tbl[20] = {3'b000, 4'd3, 8'b0_0_01_1_000};

    repeat (3) @(negedge clk_50);
    reset = 1'b0;
    check("reset_state", dut_bits, 8'b0_0_00_0_000);

    // Press latency: a press is latched on the third edge after the input falls.
    button2 = 1'b0;
    repeat (2) @(negedge clk_50);
    check("latency_before", dut_bits, 8'b0_0_00_0_000);
    @(negedge clk_50);
    check("latency_latched", dut_bits, 8'b0_0_00_0_010);
    button2 = 1'b1;
    @(negedge clk_50);
    check("latency_moving", dut_bits, 8'b1_0_00_1_010);
    $display("latency sequence done");
    pulse_reset();

    for (int i = 0; i < NVEC; i++) begin
      if (tbl[i].press != 3'b000) press_buttons(tbl[i].press);
      for (int t = 0; t < int'(tbl[i].ticks); t++) give_tick();
      check($sformatf("vec%0d", i), dut_bits, tbl[i].exp);
      $display("vec %0d: press=%b ticks=%0d -> %b", i, tbl[i].press, tbl[i].ticks, dut_bits);
    end

    // Reset for a single edge in the middle of a move from floor 1 to floor 2.
    press_buttons(3'b100);
    give_tick();
    check("before_reset", dut_bits, 8'b1_0_01_1_100);
    reset = 1'b1;
    @(negedge clk_50);
    check("reset_mid_move", dut_bits, 8'b0_0_00_0_000);
    reset = 1'b0;
    $display("mid-move reset sequence done");

`ifdef EMERGENCY_STOP_EN
    pulse_reset();
    press_buttons(3'b010);
    give_tick();
    estop = 1'b1;
    repeat (4) @(negedge clk_50);
    check("estop_frozen", dut_bits, 8'b0_0_00_1_010);
    repeat (10) give_tick();
    check("estop_held", dut_bits, 8'b0_0_00_1_010);
    estop = 1'b0;
    repeat (4) @(negedge clk_50);
    check("estop_resume", dut_bits, 8'b1_0_00_1_010);
    give_tick();
    check("estop_arrive", dut_bits, 8'b0_1_01_1_000);
    $display("estop sequence done");
`endif

    // Randomized run compared every cycle against the reference model.
    pulse_reset();
    for (int c = 0; c < 2500; c++) begin
      check($sformatf("rand_cycle%0d", c), dut_bits,
            {m_state == C_MOVE, m_state == C_DOOR, 2'(m_floor), m_up, m_req});
      reset = ($urandom_range(0, 599) == 0);
      if (button1) button1 = ($urandom_range(0, 19) != 0); else button1 = ($urandom_range(0, 2) == 0);
      if (button2) button2 = ($urandom_range(0, 19) != 0); else button2 = ($urandom_range(0, 2) == 0);
      if (button3) button3 = ($urandom_range(0, 19) != 0); else button3 = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) step = ~step;
      @(negedge clk_50);
    end
    $display("random run done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
